// File: rtl/shared_register_arbiter.sv
// rtl/shared_register_arbiter.sv - round-robin write arbiter sharing one N-bit register among M requesters
//
// Optional feature macro: REG_ARB_LOCK_EN (owner lock for back-to-back multi-beat writes)
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   rst    in   synchronous active-high reset
//   req    in   [M]   per-requester level-sensitive write request
//   lock   in   [M]   per-requester lock hint (ignored unless REG_ARB_LOCK_EN)
//   din    in   [M*N] packed write data, requester i on [i*N +: N]
//   gnt    out  [M]   registered one-hot grant
//   ack    out  [M]   one-hot single-cycle write acknowledge
//   Q      out  [N]   shared register contents
//   owner  out  [W]   index of the current or most recent grantee
//   busy   out        high whenever the FSM is not idle
module shared_register_arbiter #(
    parameter  int N = 5,
    parameter  int M = 4,
    localparam int W = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   req,
    input  logic [M-1:0]   lock,
    input  logic [M*N-1:0] din,
    output logic [M-1:0]   gnt,
    output logic [M-1:0]   ack,
    output logic [N-1:0]   Q,
    output logic [W-1:0]   owner,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_q;
    logic [M-1:0]   r_gnt;
    logic [M-1:0]   r_ack;
    logic [W-1:0]   r_owner;
    logic [W-1:0]   r_ptr;
    logic           r_busy;

    logic [W-1:0]   w_owner_nxt;
    logic [M-1:0]   w_gnt_nxt;
    logic [M-1:0]   w_ack_nxt;
    logic           w_load;
    logic [M-1:0]   w_owner_oh;
    logic [M-1:0]   w_elig;
    logic [W-1:0]   w_win;
    logic           w_relock;

    // Index increment modulo M; works for non-power-of-two M as well.
    function automatic logic [W-1:0] next_idx(input logic [W-1:0] i);
        return (i == W'(M - 1)) ? '0 : i + W'(1);
    endfunction

    function automatic logic [M-1:0] onehot(input logic [W-1:0] i);
        return {{(M-1){1'b0}}, 1'b1} << i;
    endfunction

    // First set bit of r scanning upward from base, wrapping modulo M.
    function automatic logic [W-1:0] rr_pick(input logic [M-1:0] r, input logic [W-1:0] base);
        logic [W-1:0] cand;
        logic [W-1:0] pick;
        logic         found;
        cand  = base;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = next_idx(cand);
        end
        return pick;
    endfunction

`ifdef REG_ARB_LOCK_EN
    // Number of consecutive writes by the owner within the current lock run.
    logic [2:0] r_lock_cnt;

    always_comb begin
        w_relock = (r_state == WRITE) && lock[r_owner] && req[r_owner] && (r_lock_cnt < 3'd4);
    end
`else
    logic w_lock_unused;

    always_comb begin
        w_relock = 1'b0;
    end

    assign w_lock_unused = ^lock;
`endif

    // In WRITE the current owner is masked so it cannot be re-granted straight away.
    // The pointer has already moved to owner+1 on the write edge, so the scan
    // starts just past the owner.
    always_comb begin
        w_owner_oh = onehot(r_owner);
        w_elig     = (r_state == WRITE) ? (req & ~w_owner_oh) : req;
        w_win      = rr_pick(w_elig, r_ptr);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_gnt_nxt   = '0;
        w_ack_nxt   = '0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_win;
                    w_gnt_nxt   = onehot(w_win);
                end
            end
            GRANT: begin
                if (req[r_owner]) begin
                    w_state_nxt = WRITE;
                    w_load      = 1'b1;
                    w_ack_nxt   = w_owner_oh;
                end else begin
                    // Abort: the requester withdrew, nothing is written.
                    w_state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (w_relock) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_owner_oh;
                end else if (|w_elig) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_win;
                    w_gnt_nxt   = onehot(w_win);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            if (w_load) begin
                r_q   <= din[int'(r_owner)*N +: N];
                // During a lock run the owner is re-granted without arbitration,
                // so advancing here leaves the next real arbitration unchanged.
                r_ptr <= next_idx(r_owner);
            end
        end
    end

`ifdef REG_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_cnt <= 3'd0;
        end else if (w_load) begin
            r_lock_cnt <= r_lock_cnt + 3'd1;
        end else if ((w_state_nxt == IDLE) || ((w_state_nxt == GRANT) && !w_relock)) begin
            r_lock_cnt <= 3'd0;
        end
    end
`endif

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign Q     = r_q;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule
